// File: rtl/register_file.sv
// DEPTH x WIDTH register storage: one synchronous write port, two combinational read ports, and a valid bit per register.
// Writes take 1 cycle; reads take 0 cycles, with optional same-cycle write bypass. There is no backpressure: each write is either taken or dropped.
module register_file #(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 4,
  parameter bit               BYPASS   = 1'b1,
  parameter bit               ZERO_REG = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  localparam int              AW       = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic [AW-1:0]    RADDR_A,
  output logic [WIDTH-1:0] RDATA_A,
  output logic             VALID_A,
  input  logic [AW-1:0]    RADDR_B,
  output logic [WIDTH-1:0] RDATA_B,
  output logic             VALID_B
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] vld;
  logic             wr_en;

  function automatic logic in_range(input logic [AW-1:0] addr);
    return int'(addr) < DEPTH;
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  // RST gates the write so that the bypass path cannot leak WDATA while reset is asserted.
  assign wr_en = WE && !CLR && !RST && in_range(WADDR) && !is_zero_reg(WADDR);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RST_VAL;
      vld <= '0;
    end else if (CLR) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RST_VAL;
      vld <= '0;
    end else if (wr_en) begin
      regs[WADDR] <= WDATA;
      vld[WADDR]  <= 1'b1;
    end
  end

  // Result is {valid, data}. The hardwired zero register overrides both the stored value and the bypass.
  function automatic logic [WIDTH:0] read_port(input logic [AW-1:0] raddr);
    logic [WIDTH:0] r;
    r = '0;
    if (is_zero_reg(raddr)) begin
      r = {1'b1, {WIDTH{1'b0}}};
    end else if (in_range(raddr)) begin
      if (BYPASS && wr_en && (raddr == WADDR)) r = {1'b1, WDATA};
      else                                     r = {vld[raddr], regs[raddr]};
    end
    return r;
  endfunction

  always_comb begin
    {VALID_A, RDATA_A} = read_port(RADDR_A);
  end

  always_comb begin
    {VALID_B, RDATA_B} = read_port(RADDR_B);
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file. Three parameterisations share one stimulus stream and are checked against an array model of the register file.
module tb_register_file;

  localparam int NI = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CLR = 1'b0;
  logic       WE  = 1'b0;
  logic [2:0] waddr = '0, raddr_a = '0, raddr_b = '0;
  logic [7:0] wdata = '0;

  logic [7:0] rda [NI];
  logic [7:0] rdb [NI];
  logic       va  [NI];
  logic       vb  [NI];

  // Per-instance configuration: depth, address mask, bypass, zero-register, reset value.
  int         DEP [NI] = '{4, 3, 5};
  int         MSK [NI] = '{3, 3, 7};
  bit         BYP [NI] = '{1, 0, 1};
  bit         ZR  [NI] = '{0, 1, 1};
  logic [7:0] RV  [NI] = '{8'h00, 8'h5A, 8'hC3};

  logic [7:0] mm [NI][8];
  bit         mv [NI][8];

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_on  = 1'b0;

  always #5 CLK = ~CLK;

  register_file #(.WIDTH(8), .DEPTH(4), .BYPASS(1'b1), .ZERO_REG(1'b0), .RST_VAL(8'h00)) u0 (
    .CLK(CLK), .RST(RST), .CLR(CLR), .WE(WE), .WADDR(waddr[1:0]), .WDATA(wdata),
    .RADDR_A(raddr_a[1:0]), .RDATA_A(rda[0]), .VALID_A(va[0]),
    .RADDR_B(raddr_b[1:0]), .RDATA_B(rdb[0]), .VALID_B(vb[0]));

  register_file #(.WIDTH(8), .DEPTH(3), .BYPASS(1'b0), .ZERO_REG(1'b1), .RST_VAL(8'h5A)) u1 (
    .CLK(CLK), .RST(RST), .CLR(CLR), .WE(WE), .WADDR(waddr[1:0]), .WDATA(wdata),
    .RADDR_A(raddr_a[1:0]), .RDATA_A(rda[1]), .VALID_A(va[1]),
    .RADDR_B(raddr_b[1:0]), .RDATA_B(rdb[1]), .VALID_B(vb[1]));

  register_file #(.WIDTH(8), .DEPTH(5), .BYPASS(1'b1), .ZERO_REG(1'b1), .RST_VAL(8'hC3)) u2 (
    .CLK(CLK), .RST(RST), .CLR(CLR), .WE(WE), .WADDR(waddr), .WDATA(wdata),
    .RADDR_A(raddr_a), .RDATA_A(rda[2]), .VALID_A(va[2]),
    .RADDR_B(raddr_b), .RDATA_B(rdb[2]), .VALID_B(vb[2]));

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: reset and clear restore the reset value and clear all valid bits.
  // An accepted write stores the data and sets the valid bit.
  always @(posedge CLK or posedge RST) begin
    for (int i = 0; i < NI; i++) begin
      int wa;
      wa = int'(waddr) & MSK[i];
      if (RST || CLR) begin
        for (int a = 0; a < 8; a++) begin
          mm[i][a] = RV[i];
          mv[i][a] = 1'b0;
        end
      end else if (WE && wa < DEP[i] && !(ZR[i] && wa == 0)) begin
        mm[i][wa] = wdata;
        mv[i][wa] = 1'b1;
      end
    end
  end

  function automatic void expect_rd(input int i, input logic [2:0] ra, output logic [7:0] d, output logic v);
    int a, wa;
    a  = int'(ra) & MSK[i];
    wa = int'(waddr) & MSK[i];
    d = 8'h00;
    v = 1'b0;
    if (ZR[i] && a == 0) begin
      v = 1'b1;
    end else if (a < DEP[i]) begin
      if (BYP[i] && WE && !CLR && !RST && a == wa) begin
        d = wdata;
        v = 1'b1;
      end else begin
        d = mm[i][a];
        v = mv[i][a];
      end
    end
  endfunction

  // Compare process: inputs change on the falling edge, and the outputs are checked 2 time units later.
  always @(negedge CLK) begin
    if (cmp_on) begin
      logic [7:0] ed;
      logic       ev;
      #2;
      for (int i = 0; i < NI; i++) begin
        expect_rd(i, raddr_a, ed, ev);
        chk($sformatf("u%0d.rdata_a", i), rda[i], ed);
        chk($sformatf("u%0d.valid_a", i), {7'd0, va[i]}, {7'd0, ev});
        expect_rd(i, raddr_b, ed, ev);
        chk($sformatf("u%0d.rdata_b", i), rdb[i], ed);
        chk($sformatf("u%0d.valid_b", i), {7'd0, vb[i]}, {7'd0, ev});
      end
    end
  end

  task automatic cyc(input logic r, input logic c, input logic w, input logic [2:0] wa,
                     input logic [7:0] wd, input logic [2:0] ra, input logic [2:0] rb);
    @(negedge CLK);
    RST = r; CLR = c; WE = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
    #3;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    cmp_on = 1'b1;
    // After reset: reset value with valid low; register 0 of the zero-register instances reads 0 with valid high.
    cyc(0, 0, 0, 0, 8'h00, 0, 0);
    chk("rst u0 rda0", rda[0], 8'h00);
    chk("rst u0 va0",  {7'd0, va[0]}, 8'h00);
    chk("rst u1 va0",  {7'd0, va[1]}, 8'h01);
    for (int a = 1; a < 4; a++) begin
      cyc(0, 0, 0, 0, 8'h00, 3'(a), 3'(a));
      chk($sformatf("rst u0 rdb%0d", a), rdb[0], 8'h00);
      chk($sformatf("rst u2 rda%0d", a), rda[2], 8'hC3);
      chk($sformatf("rst u1 rda%0d", a), rda[1], (a == 3) ? 8'h00 : 8'h5A);
    end
    // Write 2 <= A5, then read it back on the following cycle.
    cyc(0, 0, 1, 2, 8'hA5, 0, 0);
    cyc(0, 0, 0, 0, 8'h00, 2, 1);
    chk("wr u0 rda2", rda[0], 8'hA5);
    chk("wr u0 va2",  {7'd0, va[0]}, 8'h01);
    chk("wr u0 vb1",  {7'd0, vb[0]}, 8'h00);
    // Same-cycle read of register 1 while it is written: bypass returns new data, no bypass returns old data.
    cyc(0, 0, 1, 1, 8'h3C, 0, 1);
    chk("byp u0 rdb1", rdb[0], 8'h3C);
    chk("byp u0 vb1",  {7'd0, vb[0]}, 8'h01);
    chk("nobyp u1 rdb1", rdb[1], 8'h5A);
    cyc(0, 0, 0, 0, 8'h00, 0, 1);
    chk("post u1 rdb1", rdb[1], 8'h3C);
    // A write to the hardwired zero register is ignored.
    cyc(0, 0, 1, 0, 8'hFF, 0, 0);
    chk("zr u1 rda0", rda[1], 8'h00);
    chk("zr u2 rda0", rda[2], 8'h00);
    chk("zr u2 va0",  {7'd0, va[2]}, 8'h01);
    cyc(0, 0, 0, 0, 8'h00, 0, 0);
    chk("zr u0 rda0", rda[0], 8'hFF);
    chk("zr u1 rda0 post", rda[1], 8'h00);
    // CLR takes priority over a write issued in the same cycle.
    cyc(0, 1, 1, 3, 8'h77, 3, 2);
    cyc(0, 0, 0, 0, 8'h00, 3, 2);
    chk("clr u0 rda3", rda[0], 8'h00);
    chk("clr u0 va3",  {7'd0, va[0]}, 8'h00);
    chk("clr u0 rdb2", rdb[0], 8'h00);
    chk("clr u2 rda3", rda[2], 8'hC3);
    // Out-of-range address on the depth-3 instance: the write is dropped and a read returns 0 with valid low.
    cyc(0, 0, 1, 3, 8'h11, 3, 2);
    chk("oor u1 rda3", rda[1], 8'h00);
    cyc(0, 0, 0, 0, 8'h00, 3, 2);
    chk("oor u1 va3",  {7'd0, va[1]}, 8'h00);
    chk("oor u1 rdb2", rdb[1], 8'h5A);
    chk("oor u0 rda3", rda[0], 8'h11);
    // RST asserted in the middle of a write: outputs return to reset values at once, and the write is lost.
    cyc(1, 0, 1, 2, 8'h99, 3, 2);
    chk("rstmid u0 rda3", rda[0], 8'h00);
    chk("rstmid u0 rdb2", rdb[0], 8'h00);
    chk("rstmid u0 vb2",  {7'd0, vb[0]}, 8'h00);
    chk("rstmid u2 va0",  {7'd0, va[2]}, 8'h00);
    cyc(0, 0, 0, 0, 8'h00, 0, 2);
    chk("rstmid u0 rdb2 post", rdb[0], 8'h00);
    chk("rstmid u2 va0 post",  {7'd0, va[2]}, 8'h01);
    // Randomised traffic, with read addresses often aimed at the address being written.
    for (int n = 0; n < 500; n++) begin
      logic [2:0] wa;
      wa = 3'($urandom_range(0, 7));
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 65,
          wa, 8'($urandom),
          ($urandom_range(0, 99) < 30) ? wa : 3'($urandom_range(0, 7)),
          ($urandom_range(0, 99) < 30) ? wa : 3'($urandom_range(0, 7)));
    end
    cyc(0, 0, 0, 0, 8'h00, 0, 0);
    cmp_on = 1'b0;
    @(negedge CLK);
    #4;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
